// File: rtl/apb_master.sv
// Single-outstanding APB initiator: turns core load/store requests into SETUP/ACCESS
// transfers with lane strobes and replicated write data, and returns extended read data.
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    input  logic                  pready,
    input  logic                  perr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                state_r;
    logic [1:0]            size_r;
    logic                  unsigned_r;
    logic [7:0]            wait_cnt_r;
    logic                  req_ready_r;
    logic                  resp_valid_r;
    logic [DATA_WIDTH-1:0] resp_rdata_r;
    logic                  resp_err_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [DATA_WIDTH-1:0] pdata_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  pwrite_r;
    logic [3:0]            pstb_r;

    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = off[0];
            2'd2:    bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] strobe_f(input logic write, input logic [1:0] size,
                                            input logic [1:0] off);
        logic [3:0] stb;
        case (size)
            2'd0:    stb = 4'b0001 << off;
            2'd1:    stb = 4'b0011 << off;
            2'd2:    stb = 4'b1111;
            default: stb = 4'b0000;
        endcase
        return write ? stb : 4'b0000;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_data_f(input logic [1:0] size,
                                                          input logic [DATA_WIDTH-1:0] wdata);
        logic [DATA_WIDTH-1:0] data;
        case (size)
            2'd0:    data = {4{wdata[7:0]}};
            2'd1:    data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    // Bring the addressed lane down to bit 0, then truncate and extend to the access size.
    function automatic logic [DATA_WIDTH-1:0] load_data_f(input logic [DATA_WIDTH-1:0] rdata,
                                                          input logic [1:0] size,
                                                          input logic [1:0] off,
                                                          input logic uns);
        logic [DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-1:0] data;
        shifted = rdata >> {off, 3'b000};
        case (size)
            2'd0:    data = {{(DATA_WIDTH-8){shifted[7] & ~uns}}, shifted[7:0]};
            2'd1:    data = {{(DATA_WIDTH-16){shifted[15] & ~uns}}, shifted[15:0]};
            default: data = shifted;
        endcase
        return data;
    endfunction

    // Transfer FSM; every output is a register so the APB side never sees a glitch.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r      <= ST_IDLE;
            size_r       <= 2'd0;
            unsigned_r   <= 1'b0;
            wait_cnt_r   <= 8'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            paddr_r      <= '0;
            pdata_r      <= '0;
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            pwrite_r     <= 1'b0;
            pstb_r       <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_r <= 1'b0;
                        size_r      <= req_size;
                        unsigned_r  <= req_unsigned;
                        if (misaligned_f(req_size, req_addr[1:0])) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= '0;
                        end else begin
                            state_r  <= ST_SETUP;
                            psel_r   <= 1'b1;
                            paddr_r  <= req_addr;
                            pwrite_r <= req_write;
                            pstb_r   <= strobe_f(req_write, req_size, req_addr[1:0]);
                            pdata_r  <= lane_data_f(req_size, req_wdata);
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_r    <= ST_ACCESS;
                    penable_r  <= 1'b1;
                    wait_cnt_r <= 8'd0;
                end
                ST_ACCESS: begin
                    // pready wins over a timeout that lands on the same cycle.
                    if (pready) begin
                        state_r      <= ST_RESP;
                        psel_r       <= 1'b0;
                        penable_r    <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= perr;
                        resp_rdata_r <= (perr || pwrite_r) ? '0 :
                                        load_data_f(prdata, size_r, paddr_r[1:0], unsigned_r);
                    end else if (wait_cnt_r == TIMEOUT_CNT) begin
                        state_r      <= ST_RESP;
                        psel_r       <= 1'b0;
                        penable_r    <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                        resp_rdata_r <= '0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= '0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    psel_r       <= 1'b0;
                    penable_r    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign paddr      = paddr_r;
    assign pdata      = pdata_r;
    assign psel       = psel_r;
    assign penable    = penable_r;
    assign pwrite     = pwrite_r;
    assign pstb       = pstb_r;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a byte-level reference model predicts APB phases and
// responses, a completer model inserts wait states, and a monitor checks what the DUT does.
module tb_apb_master;
    localparam int T = 4;

    logic        pclk, presetn;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] paddr, pdata, prdata;
    logic        psel, penable, pwrite, pready, perr;
    logic [3:0]  pstb;

    typedef struct { logic [31:0] rdata; logic err; int lat; int acc; int setups; } resp_t;
    typedef struct { logic [31:0] addr; logic wr; logic [3:0] stb; logic [31:0] data; } apb_t;

    resp_t exp_q[$];
    apb_t  apb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_resp = 0;
    int cur_waits = 0;
    logic cur_perr = 1'b0;
    logic [31:0] cur_prdata = 32'h0;
    int comp_cnt;
    int acc_cyc, mon_acc, mon_setups;
    logic ready_chk;
    apb_t cur_apb;
    resp_t mon_e;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(T)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .paddr(paddr), .pdata(pdata), .prdata(prdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb),
        .pready(pready), .perr(perr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completer: raises pready after cur_waits ACCESS cycles.
    initial begin
        comp_cnt = 0;
        pready = 1'b0; perr = 1'b0; prdata = 32'h0;
        forever begin
            @(negedge pclk);
            prdata = cur_prdata;
            perr   = cur_perr;
            if (psel && penable) begin
                pready = (comp_cnt == cur_waits);
                comp_cnt++;
            end else begin
                pready = 1'b0;
                comp_cnt = 0;
            end
        end
    end

    // Monitor: checks APB phases and responses against the queued expectations.
    initial begin
        mon_acc = 0; mon_setups = 0; ready_chk = 1'b0; acc_cyc = 0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                check("resp_valid_in_reset", resp_valid, 1'b0);
                check("psel_in_reset", psel, 1'b0);
                mon_acc = 0; mon_setups = 0; ready_chk = 1'b0;
            end else begin
                if (ready_chk) begin
                    check("req_ready_after_resp", req_ready, 1'b1);
                    ready_chk = 1'b0;
                end
                if (req_valid && req_ready) acc_cyc = cyc + 1;
                if (psel && !penable) begin
                    mon_setups++;
                    checks++;
                    if (apb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_setup: actual psel=1 required psel=0 paddr=%0h", paddr);
                    end else begin
                        cur_apb = apb_q.pop_front();
                        check("setup_paddr", paddr, cur_apb.addr);
                        check("setup_pwrite", pwrite, cur_apb.wr);
                        check("setup_pstb", pstb, cur_apb.stb);
                        if (cur_apb.wr) check("setup_pdata", pdata, cur_apb.data);
                    end
                end
                if (psel && penable) begin
                    mon_acc++;
                    check("access_paddr_stable", paddr, cur_apb.addr);
                    check("access_pstb_stable", pstb, cur_apb.stb);
                    check("access_pwrite_stable", pwrite, cur_apb.wr);
                end
                if (resp_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp: actual resp_valid=1 required 0");
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("resp_rdata", resp_rdata, mon_e.rdata);
                        check("resp_err", resp_err, mon_e.err);
                        check("resp_latency", cyc - acc_cyc, mon_e.lat);
                        check("access_cycles", mon_acc, mon_e.acc);
                        check("setup_cycles", mon_setups, mon_e.setups);
                        check("psel_low_in_resp", psel | penable, 1'b0);
                    end
                    n_resp++;
                    mon_acc = 0; mon_setups = 0; ready_chk = 1'b1;
                end
            end
        end
    end

    // Reference model at byte granularity, then drive the request and wait for completion.
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                         input logic [1:0] size, input logic uns, input int waits,
                         input logic err_in, input logic [31:0] rdata_in);
        resp_t e;
        apb_t a;
        int nb, off, target;
        longint v;
        bit done;
        off = int'(addr % 4);
        nb = (size == 2'd3) ? 0 : (1 << size);
        e.rdata = 32'h0; e.err = 1'b1; e.lat = 0; e.acc = 0; e.setups = 0;
        if (nb != 0 && (addr % nb) == 0) begin
            a.addr = addr; a.wr = wr; a.stb = 4'h0; a.data = 32'h0;
            for (int i = 0; i < nb; i++) if (wr) a.stb[off + i] = 1'b1;
            for (int j = 0; j < 4; j++) a.data[8*j +: 8] = wdata[8*(j % nb) +: 8];
            apb_q.push_back(a);
            e.setups = 1;
            e.acc = (waits > T) ? T + 1 : waits + 1;
            e.lat = 1 + e.acc;
            e.err = (waits > T) || err_in;
            if (!e.err && !wr) begin
                v = 0;
                for (int i = 0; i < nb; i++) v += longint'(rdata_in[8*(off + i) +: 8]) << (8 * i);
                if (!uns && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
                e.rdata = v[31:0];
            end
        end
        exp_q.push_back(e);
        cur_waits = waits; cur_perr = err_in; cur_prdata = rdata_in;
        target = n_resp + 1;
        @(posedge pclk); #1;
        req_addr = addr; req_wdata = wdata; req_write = wr;
        req_size = size; req_unsigned = uns; req_valid = 1'b1;
        @(posedge pclk); #1;
        req_valid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge pclk);
            done = (n_resp >= target);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL resp_wait: actual no resp_valid required resp for addr %0h", addr);
            exp_q.delete();
            apb_q.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual still running required finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    logic [31:0] ra, rw, rp;
    logic [1:0]  rs;
    int          n_before;
    apb_t        ra_apb;

    initial begin
        presetn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        #12;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_psel_penable", {psel, penable}, 2'b00);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_pstb", pstb, 4'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pdata", pdata, 32'h0);
        #10 presetn = 1'b1;

        issue(32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 0, 1'b0, 32'h0);
        issue(32'h1000_0003, 32'h0, 1'b0, 2'd0, 1'b0, 2, 1'b0, 32'h8012_3456);
        issue(32'h1000_0003, 32'h0, 1'b0, 2'd0, 1'b1, 2, 1'b0, 32'h8012_3456);
        issue(32'h8000_0002, 32'h0000_1234, 1'b1, 2'd1, 1'b0, 0, 1'b0, 32'h0);
        issue(32'h8000_0001, 32'h0, 1'b0, 2'd1, 1'b0, 0, 1'b0, 32'hFFFF_FFFF);
        check("paddr_held_after_misaligned", paddr, 32'h8000_0002);
        issue(32'h2000_0000, 32'h0, 1'b0, 2'd2, 1'b0, 100, 1'b0, 32'h1234_5678);
        issue(32'h2000_0000, 32'h0, 1'b0, 2'd2, 1'b0, T, 1'b0, 32'h1234_5678);
        issue(32'h3000_0000, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b1, 32'hCAFE_F00D);
        issue(32'h3000_0002, 32'h0, 1'b0, 2'd1, 1'b0, 1, 1'b0, 32'h8001_7FFF);
        issue(32'h3000_0001, 32'hAB, 1'b1, 2'd3, 1'b0, 0, 1'b0, 32'h0);

        for (int n = 0; n < 80; n++) begin
            ra = $urandom; rw = $urandom; rp = $urandom;
            rs = 2'($urandom_range(3, 0));
            if ($urandom_range(3, 0) != 0 && rs != 2'd3) ra = ra - (ra % (32'd1 << rs));
            issue(ra, rw, 1'($urandom_range(1, 0)), rs, 1'($urandom_range(1, 0)),
                  $urandom_range(T + 2, 0), ($urandom_range(5, 0) == 0), rp);
        end

        // Reset in the middle of ACCESS abandons the transfer.
        ra_apb.addr = 32'h4000_0000; ra_apb.wr = 1'b0; ra_apb.stb = 4'h0; ra_apb.data = 32'h0;
        apb_q.push_back(ra_apb);
        cur_waits = 1000; cur_perr = 1'b0;
        n_before = n_resp;
        @(posedge pclk); #1;
        req_addr = 32'h4000_0000; req_write = 1'b0; req_size = 2'd2; req_valid = 1'b1;
        @(posedge pclk); #1;
        req_valid = 1'b0;
        @(posedge pclk);
        @(posedge pclk); #2;
        check("access_before_reset", {psel, penable}, 2'b11);
        exp_q.delete();
        apb_q.delete();
        presetn = 1'b0;
        #1;
        check("async_psel_drop", {psel, penable}, 2'b00);
        repeat (2) @(posedge pclk);
        #3 presetn = 1'b1;
        @(negedge pclk);
        check("req_ready_after_reset", req_ready, 1'b1);
        repeat (8) @(negedge pclk);
        check("no_resp_after_abandon", n_resp, n_before);
        issue(32'h5000_0008, 32'h0, 1'b0, 2'd2, 1'b1, 1, 1'b0, 32'h0BAD_CAFE);

        repeat (3) @(negedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
